// File: rtl/pcseq_pkg.sv
// Shared definitions for the PC sequencer: state encodings, default vectors
// and the cause code reported when the multiply/divide watchdog fires.
package pcseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WAIT_MDU = 3'd4,
        ST_UPDATE   = 3'd5
    } pcseq_state_e;

    localparam logic [31:0] PCSEQ_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] PCSEQ_EXC_VECTOR   = 32'h0040_0004;
    localparam logic [4:0]  PCSEQ_WDOG_CAUSE   = 5'h0D;
    localparam int          PCSEQ_WDOG_LIMIT   = 64;

    // Instruction addresses are word aligned; clear the byte offset bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_pc_next_mux.sv
// Next-PC priority selector with the sequential +4 adder.
// Priority: exception > ERET > jump > branch > pc_cur+4. Result is word aligned.
module pc_next_mux
    import pcseq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = PCSEQ_EXC_VECTOR
) (
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] pc_cur_i,
    output logic [31:0] pc_next_o
);

    logic [31:0] pc_inc;
    logic [31:0] target;

    // Sequential successor; wraps naturally at the top of the address space.
    assign pc_inc = pc_cur_i + 32'd4;

    // Fixed-priority selection of the redirect source.
    always_comb begin
        target = pc_inc;
        if (exc_i) begin
            target = EXC_VECTOR;
        end else if (eret_i) begin
            target = epc_i;
        end else if (jump_i) begin
            target = jump_target_i;
        end else if (branch_i) begin
            target = branch_target_i;
        end
        pc_next_o = word_align(target);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer owning the PC register of the MIPS core.
// Steps IDLE -> FETCH -> DECODE -> EXEC -> [WAIT_MDU] -> UPDATE, drives the
// PC register enable/data, captures EPC/cause on exceptions and counts
// retired instructions.
// Optional feature: define PCSEQ_WATCHDOG_EN to bound WAIT_MDU to WDOG_LIMIT
// cycles; on expiry wdog_trip sets (sticky) and the instruction is retired
// as an exception with cause 5'h0D.
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PCSEQ_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = PCSEQ_EXC_VECTOR,
    parameter int          WDOG_LIMIT   = PCSEQ_WDOG_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        fetch_ack,
    input  logic [31:0] pc_cur,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    input  logic        exc_req,
    input  logic [4:0]  exc_cause,
    input  logic        mdu_busy,
    output logic        pc_ena,
    output logic [31:0] pc_next,
    output logic        fetch_req,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic [4:0]  cause_out,
    output logic [31:0] retired_cnt,
    output logic [2:0]  state_o,
    output logic        wdog_trip
);

    pcseq_state_e state_q;
    logic         fetch_req_q;
    logic         epc_we_q;
    logic [31:0]  epc_out_q;
    logic [4:0]   cause_q;
    logic [31:0]  retired_q;
    logic         exc_eff;
    logic [31:0]  mux_pc;

`ifdef PCSEQ_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);

    logic [15:0]  wdog_cnt_q;
    logic         wdog_trip_q;
    logic         wdog_force_q;

    // A watchdog expiry is retired through the exception path.
    assign exc_eff   = exc_req | wdog_force_q;
    assign wdog_trip = wdog_trip_q;
`else
    logic         unused_wdog;

    assign unused_wdog = ^WDOG_LIMIT;
    assign exc_eff     = exc_req;
    assign wdog_trip   = 1'b0;
`endif

    pc_next_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_mux (
        .exc_i           (exc_eff),
        .eret_i          (eret_req),
        .epc_i           (epc_in),
        .jump_i          (jump_valid),
        .jump_target_i   (jump_target),
        .branch_i        (branch_taken),
        .branch_target_i (branch_target),
        .pc_cur_i        (pc_cur),
        .pc_next_o       (mux_pc)
    );

    // PC register load: forced during reset because the register ignores rst
    // without its enable; otherwise only in UPDATE. Requests only matter then.
    assign pc_ena  = rst | (state_q == ST_UPDATE);
    assign pc_next = (rst || state_q == ST_IDLE) ? RESET_VECTOR : mux_pc;

    assign fetch_req   = fetch_req_q;
    assign epc_we      = epc_we_q;
    assign epc_out     = epc_out_q;
    assign cause_out   = cause_q;
    assign retired_cnt = retired_q;
    assign state_o     = state_q;

    // Sequencer FSM with registered fetch request, EPC capture and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_req_q  <= 1'b0;
            epc_we_q     <= 1'b0;
            epc_out_q    <= 32'd0;
            cause_q      <= 5'd0;
            retired_q    <= 32'd0;
`ifdef PCSEQ_WATCHDOG_EN
            wdog_cnt_q   <= 16'd0;
            wdog_trip_q  <= 1'b0;
            wdog_force_q <= 1'b0;
`endif
        end else begin
            epc_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q     <= ST_FETCH;
                        fetch_req_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (fetch_ack) begin
                        state_q     <= ST_DECODE;
                        fetch_req_q <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    state_q <= mdu_busy ? ST_WAIT_MDU : ST_UPDATE;
                end
                ST_WAIT_MDU: begin
`ifdef PCSEQ_WATCHDOG_EN
                    if (!mdu_busy) begin
                        state_q    <= ST_UPDATE;
                        wdog_cnt_q <= 16'd0;
                    end else if (wdog_cnt_q == WDOG_LAST) begin
                        state_q      <= ST_UPDATE;
                        wdog_cnt_q   <= 16'd0;
                        wdog_trip_q  <= 1'b1;
                        wdog_force_q <= 1'b1;
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + 16'd1;
                    end
`else
                    if (!mdu_busy) begin
                        state_q <= ST_UPDATE;
                    end
`endif
                end
                ST_UPDATE: begin
                    if (exc_eff) begin
                        epc_we_q  <= 1'b1;
                        epc_out_q <= pc_cur;
`ifdef PCSEQ_WATCHDOG_EN
                        cause_q   <= wdog_force_q ? PCSEQ_WDOG_CAUSE : exc_cause;
`else
                        cause_q   <= exc_cause;
`endif
                    end else begin
                        retired_q <= retired_q + 32'd1;
                    end
`ifdef PCSEQ_WATCHDOG_EN
                    wdog_force_q <= 1'b0;
`endif
                    if (run) begin
                        state_q     <= ST_FETCH;
                        fetch_req_q <= 1'b1;
                    end else begin
                        state_q     <= ST_IDLE;
                        fetch_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    fetch_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Each task starts with the DUT in
// FETCH (except reset) and leaves it in FETCH for the next task.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        fetch_ack;
    logic [31:0] pc_cur;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        eret_req;
    logic [31:0] epc_in;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic        mdu_busy;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic        fetch_req;
    logic        epc_we;
    logic [31:0] epc_out;
    logic [4:0]  cause_out;
    logic [31:0] retired_cnt;
    logic [2:0]  state_o;
    logic        wdog_trip;

    int errors = 0;
    int checks = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .fetch_ack     (fetch_ack),
        .pc_cur        (pc_cur),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .eret_req      (eret_req),
        .epc_in        (epc_in),
        .exc_req       (exc_req),
        .exc_cause     (exc_cause),
        .mdu_busy      (mdu_busy),
        .pc_ena        (pc_ena),
        .pc_next       (pc_next),
        .fetch_req     (fetch_req),
        .epc_we        (epc_we),
        .epc_out       (epc_out),
        .cause_out     (cause_out),
        .retired_cnt   (retired_cnt),
        .state_o       (state_o),
        .wdog_trip     (wdog_trip)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout time=%0t limit=2000000", $time);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; fetch_ack = 1'b0; pc_cur = 32'h0;
        branch_taken = 1'b0; branch_target = 32'h0; jump_valid = 1'b0; jump_target = 32'h0;
        eret_req = 1'b0; epc_in = 32'h0; exc_req = 1'b0; exc_cause = 5'h0; mdu_busy = 1'b0;
        #1;
        checks++; if (pc_ena !== 1'b1) begin errors++; $display("FAIL reset_pc_ena got=%0b exp=1", pc_ena); end
        checks++; if (pc_next !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc_next got=%h exp=00400000", pc_next); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req got=%0b exp=0", fetch_req); end
        checks++; if (epc_we !== 1'b0 || epc_out !== 32'h0 || cause_out !== 5'h0) begin
            errors++; $display("FAIL reset_epc got we=%0b epc=%h cause=%h exp 0/0/0", epc_we, epc_out, cause_out); end
        checks++; if (retired_cnt !== 32'h0 || wdog_trip !== 1'b0) begin
            errors++; $display("FAIL reset_cnt_wdog got cnt=%0d trip=%0b exp 0/0", retired_cnt, wdog_trip); end
    endtask

    task automatic test_first_instr();
        run = 1'b1; fetch_ack = 1'b1; pc_cur = 32'h0040_0000;
        step(); step();
        rst = 1'b0;
        step();
        #1;
        checks++; if (state_o !== 3'd1 || fetch_req !== 1'b1 || pc_ena !== 1'b0) begin
            errors++; $display("FAIL first_fetch got st=%0d freq=%0b ena=%0b exp 1/1/0", state_o, fetch_req, pc_ena); end
        step();
        checks++; if (state_o !== 3'd2 || fetch_req !== 1'b0) begin
            errors++; $display("FAIL first_decode got st=%0d freq=%0b exp 2/0", state_o, fetch_req); end
        step(); step();
        #1;
        checks++; if (state_o !== 3'd5 || pc_ena !== 1'b1) begin
            errors++; $display("FAIL first_update got st=%0d ena=%0b exp 5/1", state_o, pc_ena); end
        checks++; if (pc_next !== 32'h0040_0004) begin errors++; $display("FAIL first_pc_next got=%h exp=00400004", pc_next); end
        step();
        checks++; if (retired_cnt !== 32'd1 || pc_ena !== 1'b0 || state_o !== 3'd1) begin
            errors++; $display("FAIL first_retire got cnt=%0d ena=%0b st=%0d exp 1/0/1", retired_cnt, pc_ena, state_o); end
        pc_cur = 32'h0040_0004;
    endtask

    task automatic test_jump_beats_branch();
        pc_cur = 32'h0040_0010;
        branch_taken = 1'b1; branch_target = 32'h0040_0100;
        jump_valid = 1'b1; jump_target = 32'h0040_0200;
        exc_req = 1'b1; exc_cause = 5'h09;   // outside UPDATE: must be ignored
        step(); step(); step();
        exc_req = 1'b0;
        #1;
        checks++; if (pc_next !== 32'h0040_0200 || pc_ena !== 1'b1) begin
            errors++; $display("FAIL jump_over_branch got pc=%h ena=%0b exp 00400200/1", pc_next, pc_ena); end
        step();
        checks++; if (epc_we !== 1'b0 || retired_cnt !== 32'd2) begin
            errors++; $display("FAIL exc_ignored got we=%0b cnt=%0d exp 0/2", epc_we, retired_cnt); end
        branch_taken = 1'b0; jump_valid = 1'b0;
    endtask

    task automatic test_branch_eret();
        fetch_ack = 1'b0;
        step(); step();
        #1;
        checks++; if (state_o !== 3'd1 || fetch_req !== 1'b1) begin
            errors++; $display("FAIL fetch_stall got st=%0d freq=%0b exp 1/1", state_o, fetch_req); end
        fetch_ack = 1'b1;
        step(); step(); step();
        pc_cur = 32'h0040_0200; branch_taken = 1'b1; branch_target = 32'h0040_0100;
        #1;
        checks++; if (state_o !== 3'd5 || pc_next !== 32'h0040_0100) begin
            errors++; $display("FAIL branch got st=%0d pc=%h exp 5/00400100", state_o, pc_next); end
        step();
        branch_taken = 1'b0;
        eret_req = 1'b1; epc_in = 32'h0040_0ABC; jump_valid = 1'b1; jump_target = 32'h0040_0300;
        step(); step(); step();
        #1;
        checks++; if (pc_next !== 32'h0040_0ABC) begin errors++; $display("FAIL eret_over_jump got=%h exp=00400abc", pc_next); end
        step();
        eret_req = 1'b0; jump_valid = 1'b0;
        checks++; if (retired_cnt !== 32'd4) begin errors++; $display("FAIL retire_count4 got=%0d exp=4", retired_cnt); end
    endtask

    task automatic test_exception();
        step(); step(); step();
        pc_cur = 32'h0040_0020; exc_req = 1'b1; exc_cause = 5'h08; eret_req = 1'b1; epc_in = 32'h0040_0500;
        #1;
        checks++; if (pc_next !== 32'h0040_0004 || epc_we !== 1'b0) begin
            errors++; $display("FAIL exc_pc_next got pc=%h we=%0b exp 00400004/0", pc_next, epc_we); end
        step();
        exc_req = 1'b0; eret_req = 1'b0;
        checks++; if (epc_we !== 1'b1 || epc_out !== 32'h0040_0020 || cause_out !== 5'h08) begin
            errors++; $display("FAIL exc_capture got we=%0b epc=%h cause=%h exp 1/00400020/08", epc_we, epc_out, cause_out); end
        checks++; if (retired_cnt !== 32'd4) begin errors++; $display("FAIL exc_no_retire got=%0d exp=4", retired_cnt); end
        step();
        checks++; if (epc_we !== 1'b0 || epc_out !== 32'h0040_0020) begin
            errors++; $display("FAIL exc_strobe_once got we=%0b epc=%h exp 0/00400020", epc_we, epc_out); end
        step(); step(); step();
    endtask

    task automatic test_wrap_align();
        step(); step(); step();
        pc_cur = 32'hFFFF_FFFC;
        #1;
        checks++; if (pc_next !== 32'h0000_0000) begin errors++; $display("FAIL pc_wrap got=%h exp=00000000", pc_next); end
        step();
        jump_valid = 1'b1; jump_target = 32'h0040_0203;
        step(); step(); step();
        #1;
        checks++; if (pc_next !== 32'h0040_0200) begin errors++; $display("FAIL pc_align got=%h exp=00400200", pc_next); end
        step();
        jump_valid = 1'b0;
        checks++; if (retired_cnt !== 32'd7) begin errors++; $display("FAIL retire_count7 got=%0d exp=7", retired_cnt); end
    endtask

    task automatic test_mdu_stall();
        int first = 0;
        pc_cur = 32'h0040_0040;
        for (int c = 1; c <= 60; c++) begin
            mdu_busy = (c >= 3 && c <= 34);
            #1;
            if (pc_ena === 1'b1) begin
                first = c;
                break;
            end
            step();
        end
        checks++; if (first != 36) begin errors++; $display("FAIL mdu_latency got=%0d exp=36", first); end
        checks++; if (state_o !== 3'd5 || pc_next !== 32'h0040_0044) begin
            errors++; $display("FAIL mdu_update got st=%0d pc=%h exp 5/00400044", state_o, pc_next); end
        mdu_busy = 1'b0;
        step();
        checks++; if (retired_cnt !== 32'd8) begin errors++; $display("FAIL retire_count8 got=%0d exp=8", retired_cnt); end
    endtask

    task automatic test_watchdog();
        int n = 0;
        pc_cur = 32'h0040_0080; exc_cause = 5'h03;
        step(); step();
        mdu_busy = 1'b1;
        step();
        #1;
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL wdog_enter_wait got=%0d exp=4", state_o); end
`ifdef PCSEQ_WATCHDOG_EN
        while (state_o === 3'd4 && n < 200) begin
            n++;
            step();
        end
        checks++; if (n != 64) begin errors++; $display("FAIL wdog_wait_cycles got=%0d exp=64", n); end
        checks++; if (state_o !== 3'd5 || wdog_trip !== 1'b1 || pc_next !== 32'h0040_0004) begin
            errors++; $display("FAIL wdog_trip got st=%0d trip=%0b pc=%h exp 5/1/00400004", state_o, wdog_trip, pc_next); end
        mdu_busy = 1'b0;
        step();
        checks++; if (epc_we !== 1'b1 || cause_out !== 5'h0D || epc_out !== 32'h0040_0080 || retired_cnt !== 32'd8) begin
            errors++; $display("FAIL wdog_capture got we=%0b cause=%h epc=%h cnt=%0d exp 1/0d/00400080/8",
                               epc_we, cause_out, epc_out, retired_cnt); end
        step();
        checks++; if (wdog_trip !== 1'b1) begin errors++; $display("FAIL wdog_sticky got=%0b exp=1", wdog_trip); end
        step(); step(); step();
`else
        repeat (100) step();
        checks++; if (state_o !== 3'd4 || wdog_trip !== 1'b0) begin
            errors++; $display("FAIL wait_forever got st=%0d trip=%0b exp 4/0", state_o, wdog_trip); end
        mdu_busy = 1'b0;
        step();
        checks++; if (state_o !== 3'd5) begin errors++; $display("FAIL wait_release got=%0d exp=5", state_o); end
        step();
        checks++; if (retired_cnt !== 32'd9) begin errors++; $display("FAIL retire_count9 got=%0d exp=9", retired_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        step(); step();
        mdu_busy = 1'b1;
        step();
        #1;
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL mid_wait got=%0d exp=4", state_o); end
        rst = 1'b1;
        #1;
        checks++; if (state_o !== 3'd0 || pc_ena !== 1'b1 || pc_next !== 32'h0040_0000) begin
            errors++; $display("FAIL mid_reset got st=%0d ena=%0b pc=%h exp 0/1/00400000", state_o, pc_ena, pc_next); end
        checks++; if (retired_cnt !== 32'd0 || fetch_req !== 1'b0 || wdog_trip !== 1'b0 || epc_we !== 1'b0) begin
            errors++; $display("FAIL mid_reset_regs got cnt=%0d freq=%0b trip=%0b we=%0b exp 0/0/0/0",
                               retired_cnt, fetch_req, wdog_trip, epc_we); end
        step();
        rst = 1'b0; mdu_busy = 1'b0;
        step();
        #1;
        checks++; if (state_o !== 3'd1 || pc_ena !== 1'b0) begin
            errors++; $display("FAIL mid_restart got st=%0d ena=%0b exp 1/0", state_o, pc_ena); end
    endtask

    initial begin
        test_reset();
        test_first_instr();
        test_jump_beats_branch();
        test_branch_eret();
        test_exception();
        test_wrap_align();
        test_mdu_stall();
        test_watchdog();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
